// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, bit-period default, counter width.
// Used by both receiver and transmitter.
package uart_pkg;

    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] CLKS_PER_BIT_DEF = 10'd868;  // 115200 baud at 100 MHz

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_CLEANUP = 3'd5
    } uart_state_t;

    // Even parity bit for an 8-bit payload.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART interface: serial line in, byte and status pulses out.
// slave = the receiver, master = whoever drives the line and consumes bytes.
interface uart_rx_if;
    logic       i_Rx_Serial;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_Frame_Err;
    logic       o_Rx_Parity_Err;
    logic       o_Rx_Active;

    modport slave (
        input  i_Rx_Serial,
        output o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err, o_Rx_Parity_Err, o_Rx_Active
    );

    modport master (
        output i_Rx_Serial,
        input  o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err, o_Rx_Parity_Err, o_Rx_Active
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 1 so an
// idle-high line does not look like a start edge coming out of reset.
module uart_sync2 (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_D,
    output logic o_Q
);
    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            meta <= 1'b1;
            o_Q  <= 1'b1;
        end else begin
            meta <= i_D;
            o_Q  <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: start + 8 data bits (LSB first) + stop, mid-bit sampling.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter logic [CNT_W-1:0] CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic     i_Clock,
    input  logic     i_Reset,
    uart_rx_if.slave rx
);
    localparam logic [CNT_W-1:0] LAST_CNT = CLKS_PER_BIT - 10'd1;
    localparam logic [CNT_W-1:0] HALF_CNT = (CLKS_PER_BIT - 10'd1) >> 1;

    logic             rx_s;
    uart_state_t      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       rx_byte, rx_byte_n;
    logic             dv, dv_n;
    logic             ferr, ferr_n;
    logic             active, active_n;
    logic             brk, brk_n;      // stop bit was low; wait for line high
    logic             at_last;

    uart_sync2 u_sync (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_D     (rx.i_Rx_Serial),
        .o_Q     (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic perr, perr_n;
    logic perr_pend, perr_pend_n;      // parity verdict held until stop sampling
`endif

    assign at_last = (cnt == LAST_CNT);

    // State and datapath registers.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            rx_byte   <= '0;
            dv        <= 1'b0;
            ferr      <= 1'b0;
            active    <= 1'b0;
            brk       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr      <= 1'b0;
            perr_pend <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            rx_byte   <= rx_byte_n;
            dv        <= dv_n;
            ferr      <= ferr_n;
            active    <= active_n;
            brk       <= brk_n;
`ifdef UART_RX_PARITY_EN
            perr      <= perr_n;
            perr_pend <= perr_pend_n;
`endif
        end
    end

    // Next-state and output decode; pulses default low so they last one cycle.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        rx_byte_n = rx_byte;
        dv_n      = 1'b0;
        ferr_n    = 1'b0;
        active_n  = active;
        brk_n     = brk;
`ifdef UART_RX_PARITY_EN
        perr_n      = 1'b0;
        perr_pend_n = perr_pend;
`endif
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (brk) begin
                    if (rx_s) brk_n = 1'b0;
                end else if (!rx_s) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt == HALF_CNT) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n  = S_DATA;
                        active_n = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 10'd1;
                end
            end
            S_DATA: begin
                if (at_last) begin
                    cnt_n          = '0;
                    rx_byte_n[idx] = rx_s;
                    if (idx == 3'd7) begin
                        idx_n = '0;
`ifdef UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 10'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (at_last) begin
                    cnt_n       = '0;
                    perr_pend_n = (rx_s != even_parity(rx_byte));
                    state_n     = S_STOP;
                end else begin
                    cnt_n = cnt + 10'd1;
                end
            end
`endif
            S_STOP: begin
                if (at_last) begin
                    cnt_n    = '0;
                    active_n = 1'b0;
                    state_n  = S_CLEANUP;
`ifdef UART_RX_PARITY_EN
                    perr_n      = perr_pend;
                    perr_pend_n = 1'b0;
                    dv_n        = rx_s && !perr_pend;
`else
                    dv_n        = rx_s;
`endif
                    ferr_n = !rx_s;
                    brk_n  = !rx_s;
                end else begin
                    cnt_n = cnt + 10'd1;
                end
            end
            S_CLEANUP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n  = S_IDLE;
                cnt_n    = '0;
                idx_n    = '0;
                active_n = 1'b0;
            end
        endcase
    end

    assign rx.o_Rx_DV        = dv;
    assign rx.o_Rx_Byte      = rx_byte;
    assign rx.o_Rx_Frame_Err = ferr;
    assign rx.o_Rx_Active    = active;
`ifdef UART_RX_PARITY_EN
    assign rx.o_Rx_Parity_Err = perr;
`else
    assign rx.o_Rx_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 8 clocks per bit.
// Parity cases are compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int BIT = 8;

    logic i_Clock = 1'b0;
    logic i_Reset = 1'b1;
    uart_rx_if u_if ();

    uart_rx #(.CLKS_PER_BIT(10'd8)) dut (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .rx      (u_if.slave)
    );

    always #5 i_Clock = ~i_Clock;

    int checks = 0;
    int errors = 0;

    // Pulse monitor: counts and most recent received byte.
    int         dv_cnt = 0, ferr_cnt = 0, perr_cnt = 0, act_cnt = 0;
    logic [7:0] last_byte = 8'h00;
    logic [7:0] dv_hist [$];

    always @(negedge i_Clock) begin
        if (u_if.o_Rx_DV) begin
            dv_cnt++;
            last_byte = u_if.o_Rx_Byte;
            dv_hist.push_back(u_if.o_Rx_Byte);
        end
        if (u_if.o_Rx_Frame_Err)  ferr_cnt++;
        if (u_if.o_Rx_Parity_Err) perr_cnt++;
        if (u_if.o_Rx_Active)     act_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic line_for(input logic v, input int cycles);
        u_if.i_Rx_Serial = v;
        repeat (cycles) @(negedge i_Clock);
    endtask

    // One frame; par_ok=0 sends the wrong parity bit when parity is built in.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok);
        line_for(1'b0, BIT);
        for (int i = 0; i < 8; i++) line_for(d[i], BIT);
`ifdef UART_RX_PARITY_EN
        line_for((^d) ^ ~par_ok, BIT);
`else
        if (par_ok) begin end
`endif
        line_for(stop, BIT);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_dv;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [6];

    int d0, f0, p0, a0;

    initial begin
        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_dv: 1, exp_ferr: 0};
        vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_dv: 0, exp_ferr: 1};
        vecs[2] = '{data: 8'h42, stop: 1'b1, exp_dv: 1, exp_ferr: 0};
        vecs[3] = '{data: 8'h55, stop: 1'b1, exp_dv: 1, exp_ferr: 0};
        vecs[4] = '{data: 8'h01, stop: 1'b1, exp_dv: 1, exp_ferr: 0};
        vecs[5] = '{data: 8'h80, stop: 1'b1, exp_dv: 1, exp_ferr: 0};

        u_if.i_Rx_Serial = 1'b1;
        repeat (4) @(negedge i_Clock);
        chk("reset_outputs",
            {24'h0, u_if.o_Rx_Byte, u_if.o_Rx_DV, u_if.o_Rx_Frame_Err,
             u_if.o_Rx_Parity_Err, u_if.o_Rx_Active}, 32'h0);
        i_Reset = 1'b0;
        line_for(1'b1, 10);

        // Table-driven single frames, each followed by an idle gap.
        for (int v = 0; v < 6; v++) begin
            d0 = dv_cnt; f0 = ferr_cnt; p0 = perr_cnt;
            send_frame(vecs[v].data, vecs[v].stop, 1'b1);
            line_for(1'b1, 2 * BIT);
            chk($sformatf("vec%0d_dv", v), dv_cnt - d0, vecs[v].exp_dv);
            chk($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
            chk($sformatf("vec%0d_perr", v), perr_cnt - p0, 0);
            if (vecs[v].exp_dv != 0)
                chk($sformatf("vec%0d_byte", v), last_byte, vecs[v].data);
        end

        // Back-to-back frames, no idle gap.
        d0 = dv_cnt;
        dv_hist.delete();
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        line_for(1'b1, 2 * BIT);
        chk("b2b_dv_count", dv_cnt - d0, 2);
        if (dv_hist.size() == 2) begin
            chk("b2b_first", dv_hist[0], 8'h00);
            chk("b2b_second", dv_hist[1], 8'hFF);
        end else begin
            chk("b2b_hist_size", dv_hist.size(), 2);
        end

        // Three-cycle glitch: rejected, nothing pulses, byte untouched.
        d0 = dv_cnt; f0 = ferr_cnt; a0 = act_cnt;
        line_for(1'b0, 3);
        line_for(1'b1, 3 * BIT);
        chk("glitch_dv", dv_cnt - d0, 0);
        chk("glitch_ferr", ferr_cnt - f0, 0);
        chk("glitch_active", act_cnt - a0, 0);
        chk("glitch_byte_hold", u_if.o_Rx_Byte, 8'hFF);

        // Break: long low gives one frame error, then a clean frame.
        d0 = dv_cnt; f0 = ferr_cnt;
        line_for(1'b0, 30 * BIT);
        line_for(1'b1, 2 * BIT);
        chk("break_ferr", ferr_cnt - f0, 1);
        chk("break_dv", dv_cnt - d0, 0);
        d0 = dv_cnt;
        send_frame(8'h5A, 1'b1, 1'b1);
        line_for(1'b1, 2 * BIT);
        chk("after_break_dv", dv_cnt - d0, 1);
        chk("after_break_byte", last_byte, 8'h5A);

        // Reset during data bit 4 of 0x81: outputs clear, no pulses, next frame ok.
        d0 = dv_cnt; f0 = ferr_cnt;
        line_for(1'b0, BIT);
        for (int i = 0; i < 4; i++) line_for(i == 0 ? 1'b1 : 1'b0, BIT);
        line_for(1'b0, 3);
        i_Reset = 1'b1;
        u_if.i_Rx_Serial = 1'b1;
        repeat (2) @(negedge i_Clock);
        chk("midreset_outputs",
            {24'h0, u_if.o_Rx_Byte, u_if.o_Rx_DV, u_if.o_Rx_Frame_Err,
             u_if.o_Rx_Parity_Err, u_if.o_Rx_Active}, 32'h0);
        i_Reset = 1'b0;
        line_for(1'b1, 3 * BIT);
        chk("midreset_no_dv", dv_cnt - d0, 0);
        chk("midreset_no_ferr", ferr_cnt - f0, 0);
        send_frame(8'h81, 1'b1, 1'b1);
        line_for(1'b1, 2 * BIT);
        chk("post_reset_dv", dv_cnt - d0, 1);
        chk("post_reset_byte", last_byte, 8'h81);

`ifdef UART_RX_PARITY_EN
        // Wrong parity: parity error pulse, no data valid.
        d0 = dv_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        line_for(1'b1, 2 * BIT);
        chk("par_bad_perr", perr_cnt - p0, 1);
        chk("par_bad_dv", dv_cnt - d0, 0);
        // Correct parity (1 for 0x07): clean receive.
        d0 = dv_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        line_for(1'b1, 2 * BIT);
        chk("par_ok_perr", perr_cnt - p0, 0);
        chk("par_ok_dv", dv_cnt - d0, 1);
        chk("par_ok_byte", last_byte, 8'h07);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
